// File: rtl/craps_roll_driver.sv
// craps_roll_driver: turns a pushbutton or an auto-play timer into single-cycle
// roll strobes for the dice game, waits for the win/loss outcome, keeps BCD
// tallies and pulses an active-low game reset before the next game.
module craps_roll_driver #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned AUTO_INTERVAL   = 1024,
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned RESULT_HOLD     = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       auto_en,
    input  logic       win,
    input  logic       loss,
    output logic       roll,
    output logic       game_reset_n,
    output logic [2:0] state,
    output logic [7:0] wins_bcd,
    output logic [7:0] losses_bcd,
    output logic [3:0] roll_count
);

    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned AUTO_W   = $clog2(AUTO_INTERVAL + 1);
    localparam int unsigned WAIT_MAX = (SETTLE_CYCLES > RESULT_HOLD) ? SETTLE_CYCLES : RESULT_HOLD;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ROLL   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_CLEAR  = 3'd5;

    logic [1:0]        sync_q;
    logic              db_level;
    logic              db_prev;
    logic [DB_W-1:0]   db_cnt;
    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_req;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        state_next;
    logic              req;

    // Saturating two-digit BCD increment.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99) begin
            return v;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // Synchronize the button and debounce it; the count restarts whenever the
    // synchronized level falls back to the current debounced level.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q   <= 2'b00;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            db_prev <= db_level;
            if (sync_q[1] == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level <= sync_q[1];
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Auto-play timer: runs only while idle with auto_en, pulses a registered request.
    always_ff @(posedge clock) begin
        if (!reset) begin
            auto_cnt <= '0;
            auto_req <= 1'b0;
        end else if (auto_en && (state == S_IDLE)) begin
            if (auto_cnt == AUTO_W'(AUTO_INTERVAL - 1)) begin
                auto_cnt <= '0;
                auto_req <= 1'b1;
            end else begin
                auto_cnt <= auto_cnt + AUTO_W'(1);
                auto_req <= 1'b0;
            end
        end else begin
            auto_cnt <= '0;
            auto_req <= 1'b0;
        end
    end

    assign req = (db_level & ~db_prev) | auto_req;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (req) state_next = S_ROLL;
            S_ROLL:   state_next = S_SETTLE;
            S_SETTLE: if (wait_cnt == WAIT_W'(SETTLE_CYCLES - 1)) state_next = S_CHECK;
            S_CHECK:  state_next = (win || loss) ? S_HOLD : S_IDLE;
            S_HOLD:   if (wait_cnt == WAIT_W'(RESULT_HOLD - 1)) state_next = S_CLEAR;
            S_CLEAR:  state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Dwell counter for SETTLE and HOLD; restarts on every state change.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if ((state_next != state) || ((state != S_SETTLE) && (state != S_HOLD))) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Registered outputs: roll strobe, game reset, roll counter and tallies.
    always_ff @(posedge clock) begin
        if (!reset) begin
            roll         <= 1'b0;
            game_reset_n <= 1'b0;
            roll_count   <= 4'd0;
            wins_bcd     <= 8'h00;
            losses_bcd   <= 8'h00;
        end else begin
            roll         <= (state_next == S_ROLL);
            game_reset_n <= (state_next != S_CLEAR);
            if (state_next == S_ROLL) begin
                if (roll_count != 4'd15) roll_count <= roll_count + 4'd1;
            end else if (state_next == S_CLEAR) begin
                roll_count <= 4'd0;
            end
            if (state == S_CHECK) begin
                if (loss) begin
                    losses_bcd <= bcd_inc(losses_bcd);
                end else if (win) begin
                    wins_bcd <= bcd_inc(wins_bcd);
                end
            end
        end
    end

endmodule

// File: tb/tb_craps_roll_driver.sv
// Testbench for craps_roll_driver: directed game scenarios plus randomized
// outcomes, checked against a tally/roll-count model kept in plain integers.
module tb_craps_roll_driver;

    localparam int SC = 4;
    localparam int RH = 256;
    localparam int AI = 1024;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_raw;
    logic       auto_en;
    logic       win;
    logic       loss;
    logic       roll;
    logic       game_reset_n;
    logic [2:0] state;
    logic [7:0] wins_bcd;
    logic [7:0] losses_bcd;
    logic [3:0] roll_count;

    int checks   = 0;
    int failures = 0;
    int exp_wins   = 0;
    int exp_losses = 0;
    int exp_rc     = 0;

    craps_roll_driver dut (
        .clock        (clock),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .auto_en      (auto_en),
        .win          (win),
        .loss         (loss),
        .roll         (roll),
        .game_reset_n (game_reset_n),
        .state        (state),
        .wins_bcd     (wins_bcd),
        .losses_bcd   (losses_bcd),
        .roll_count   (roll_count)
    );

    always #5 clock = ~clock;

    // Global time limit so the run can never hang.
    initial begin
        #3000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal count to saturated two-digit BCD.
    function automatic logic [7:0] bcd(input int n);
        int m;
        m = (n > 99) ? 99 : n;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic rnd_wl();
        win  = 1'($urandom_range(0, 1));
        loss = 1'($urandom_range(0, 1));
    endtask

    task automatic chk_tallies(input string tag);
        chk({tag, "_wins"}, 32'(wins_bcd), 32'(bcd(exp_wins)));
        chk({tag, "_losses"}, 32'(losses_bcd), 32'(bcd(exp_losses)));
    endtask

    // One game. outcome: 0 none (point), 1 win, 2 loss, 3 win+loss.
    task automatic play(input int outcome, input bit manual, input bit bounce,
                        input bit press_hold, input bit auto_hold, input bit rst_hold);
        int lat;
        int rolls;
        int hold_cycles;
        bit got;
        win  = 1'b0;
        loss = 1'b0;
        lat  = 0;
        got  = 1'b0;
        if (manual) begin
            btn_raw = 1'b0;
            rolls = 0;
            for (int i = 0; i < 25; i++) begin
                step();
                if (roll) rolls++;
            end
            chk("idle_no_roll", 32'(rolls), 32'd0);
            if (bounce) begin
                for (int t = 0; t < 12; t++) begin
                    btn_raw = ~btn_raw;
                    repeat (5) step();
                end
            end
            btn_raw = 1'b1;
            while (!got && lat < 40) begin
                step();
                lat++;
                if (roll) got = 1'b1;
            end
            chk("manual_roll_seen", 32'(got), 32'd1);
            checks++;
            assert (lat >= 18 && lat <= 20) else begin
                failures++;
                $error("FAIL manual_latency: observed=%0d expected=18..20", lat);
            end
            if (!bounce) btn_raw = 1'b0;
        end else begin
            while (!got && lat < 1100) begin
                if (roll) got = 1'b1;
                else begin
                    step();
                    lat++;
                end
            end
            chk("auto_latency", 32'(lat), 32'(AI + 1));
            auto_en = 1'b0;
        end
        if (!got) return;
        exp_rc = (exp_rc < 15) ? exp_rc + 1 : 15;

        for (int i = 1; i <= SC; i++) begin
            rnd_wl();
            step();
            if (i == 1) chk("roll_one_cycle", 32'(roll), 32'd0);
            if (i == SC) chk("settle_state", 32'(state), 32'd2);
        end
        rnd_wl();
        step();
        chk("check_state", 32'(state), 32'd3);
        win  = (outcome == 1 || outcome == 3);
        loss = (outcome >= 2);
        step();
        rnd_wl();

        if (outcome == 0) begin
            chk("point_to_idle", 32'(state), 32'd0);
            chk("point_roll_count", 32'(roll_count), 32'(exp_rc));
            chk_tallies("point");
            if (bounce) begin
                rolls = 0;
                for (int i = 0; i < 30; i++) begin
                    step();
                    if (roll) rolls++;
                end
                chk("bounce_single_roll", 32'(rolls), 32'd0);
                btn_raw = 1'b0;
            end
            win  = 1'b0;
            loss = 1'b0;
            return;
        end

        if (outcome >= 2) exp_losses++;
        else exp_wins++;
        chk("hold_entry", 32'(state), 32'd4);
        chk("hold_roll_count", 32'(roll_count), 32'(exp_rc));
        chk_tallies("result");

        hold_cycles = 1;
        rolls = 0;
        while (state == 3'd4 && hold_cycles < 300) begin
            if (press_hold && hold_cycles == 10) btn_raw = 1'b1;
            if (press_hold && hold_cycles == 60) btn_raw = 1'b0;
            if (auto_hold && hold_cycles == 5) auto_en = 1'b1;
            if (rst_hold && hold_cycles == 100) begin
                reset = 1'b0;
                step();
                exp_wins   = 0;
                exp_losses = 0;
                exp_rc     = 0;
                chk("rst_state", 32'(state), 32'd0);
                chk("rst_roll", 32'(roll), 32'd0);
                chk("rst_game_reset_n", 32'(game_reset_n), 32'd0);
                chk("rst_roll_count", 32'(roll_count), 32'(exp_rc));
                chk_tallies("rst");
                reset = 1'b1;
                step();
                chk("rst_release_grn", 32'(game_reset_n), 32'd1);
                win  = 1'b0;
                loss = 1'b0;
                return;
            end
            rnd_wl();
            step();
            if (roll) rolls++;
            if (state == 3'd4) hold_cycles++;
        end
        chk("hold_length", 32'(hold_cycles), 32'(RH));
        chk("hold_no_roll", 32'(rolls), 32'd0);
        chk("clear_state", 32'(state), 32'd5);
        chk("clear_grn_low", 32'(game_reset_n), 32'd0);
        exp_rc = 0;
        step();
        chk("after_clear_grn", 32'(game_reset_n), 32'd1);
        chk("after_clear_state", 32'(state), 32'd0);
        chk("after_clear_rc", 32'(roll_count), 32'(exp_rc));
        win  = 1'b0;
        loss = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        btn_raw = 1'b0;
        auto_en = 1'b0;
        win     = 1'b0;
        loss    = 1'b0;

        // Reset held with a toggling button.
        for (int i = 0; i < 3; i++) begin
            btn_raw = ~btn_raw;
            step();
        end
        chk("reset_roll", 32'(roll), 32'd0);
        chk("reset_grn", 32'(game_reset_n), 32'd0);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_rc", 32'(roll_count), 32'd0);
        chk_tallies("reset");
        reset   = 1'b1;
        btn_raw = 1'b0;
        step();
        chk("release_grn", 32'(game_reset_n), 32'd1);

        // Win path with a press during HOLD.
        play(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Point phase: three point rolls then a loss.
        for (int i = 0; i < 3; i++) play(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        play(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Bouncing button yields one roll.
        play(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Roll counter saturation, then a loss.
        for (int i = 0; i < 16; i++) play(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        play(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous win and loss counts as a loss.
        play(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized outcomes.
        for (int i = 0; i < 30; i++) begin
            play(int'($urandom_range(0, 3)), 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        // Drive wins past 99 to exercise carry and saturation.
        while (exp_wins < 120) play(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Auto-play from IDLE entry, then reset in the middle of HOLD.
        play(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        play(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Tallies restart after reset.
        play(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
